// File: rtl/ddr_frame_wr_sched.sv
// rtl/ddr_frame_wr_sched.sv - frame-at-a-time AXI write burst scheduler for the camera prefetch FIFO
// Rotates across FRAME_NUM buffers; a frame_start while busy abandons and rewrites the current buffer.

module ddr_frame_wr_sched #(
  parameter int unsigned ADDR_WIDTH   = 28,
  parameter int unsigned BURST_LEN    = 16,
  parameter int unsigned FRAME_WORDS  = 115200,
  parameter logic [31:0] FRAME_BASE   = 32'h0000_0000,
  parameter logic [31:0] FRAME_STRIDE = 32'h0020_0000,
  parameter int unsigned FRAME_NUM    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  output logic                  fifo_rd_en,
  input  logic                  fifo_rd_vld,
  input  logic [127:0]          fifo_rd_data,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic [7:0]            awlen,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [127:0]          wdata,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic                  bvalid,
  input  logic [1:0]            bresp,
  output logic                  bready,
  output logic [1:0]            wr_frame_idx,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  bresp_err
);

  localparam int unsigned WC_W     = $clog2(FRAME_WORDS + 1);
  localparam logic [1:0]  BUF_LAST = 2'(FRAME_NUM - 1);
  localparam logic [8:0]  BURST_L  = 9'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

  state_t                state_q, state_d;
  logic [1:0]            buf_idx_q, buf_idx_d;
  logic [1:0]            wr_frame_idx_q, wr_frame_idx_d;
  logic [WC_W-1:0]       word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [8:0]            blen_q, blen_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  start_pend_q, start_pend_d;
  logic                  aw_hold_q, aw_hold_d;
  logic                  bresp_err_q, bresp_err_d;

  logic [31:0]           remain;
  logic [8:0]            blen_c;
  logic [1:0]            buf_next;
  logic                  frame_last;
  logic                  aw_v;
  logic                  w_v;
  logic                  w_l;

  function automatic logic [ADDR_WIDTH-1:0] buf_base(input logic [1:0] idx);
    return ADDR_WIDTH'(FRAME_BASE) + ADDR_WIDTH'(FRAME_STRIDE) * ADDR_WIDTH'(idx);
  endfunction

  assign remain       = FRAME_WORDS - 32'(word_cnt_q);
  assign blen_c       = (remain < BURST_LEN) ? 9'(remain) : BURST_L;
  assign buf_next     = (buf_idx_q == BUF_LAST) ? 2'd0 : buf_idx_q + 2'd1;
  assign frame_last   = (32'(word_cnt_q) + 32'(blen_q)) == FRAME_WORDS;
  assign wr_frame_idx = wr_frame_idx_q;
  assign bresp_err    = bresp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      buf_idx_q      <= 2'd0;
      wr_frame_idx_q <= BUF_LAST;
      word_cnt_q     <= '0;
      addr_q         <= '0;
      blen_q         <= '0;
      beat_cnt_q     <= '0;
      start_pend_q   <= 1'b0;
      aw_hold_q      <= 1'b0;
      bresp_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      buf_idx_q      <= buf_idx_d;
      wr_frame_idx_q <= wr_frame_idx_d;
      word_cnt_q     <= word_cnt_d;
      addr_q         <= addr_d;
      blen_q         <= blen_d;
      beat_cnt_q     <= beat_cnt_d;
      start_pend_q   <= start_pend_d;
      aw_hold_q      <= aw_hold_d;
      bresp_err_q    <= bresp_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    buf_idx_d      = buf_idx_q;
    wr_frame_idx_d = wr_frame_idx_q;
    word_cnt_d     = word_cnt_q;
    addr_d         = addr_q;
    blen_d         = blen_q;
    beat_cnt_d     = beat_cnt_q;
    start_pend_d   = start_pend_q;
    aw_hold_d      = aw_hold_q;
    bresp_err_d    = bresp_err_q;
    aw_v           = 1'b0;
    w_v            = 1'b0;
    w_l            = 1'b0;
    fifo_rd_en     = 1'b0;
    awaddr         = '0;
    awlen          = '0;
    awvalid        = 1'b0;
    wdata          = '0;
    wlast          = 1'b0;
    wvalid         = 1'b0;
    bready         = 1'b0;
    frame_done     = 1'b0;
    frame_abort    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          word_cnt_d = '0;
          addr_d     = buf_base(buf_idx_q);
          state_d    = S_ADDR;
        end
      end

      S_ADDR: begin
        // Only offer the burst once data is available, then keep it stable until accepted.
        aw_v    = fifo_rd_vld | aw_hold_q;
        awvalid = aw_v;
        awaddr  = addr_q;
        awlen   = 8'(blen_c - 9'd1);
        if (aw_v && awready) begin
          blen_d       = blen_c;
          beat_cnt_d   = '0;
          aw_hold_d    = 1'b0;
          start_pend_d = frame_start;
          state_d      = S_DATA;
        end else if (frame_start) begin
          frame_abort = 1'b1;
          aw_hold_d   = 1'b0;
          word_cnt_d  = '0;
          addr_d      = buf_base(buf_idx_q);
        end else begin
          aw_hold_d = aw_v;
        end
      end

      S_DATA: begin
        // An abandoned frame still finishes its burst with zero padding so AXI stays consistent.
        w_l    = beat_cnt_q == 8'(blen_q - 9'd1);
        wlast  = w_l;
        if (start_pend_q) begin
          w_v = 1'b1;
        end else begin
          w_v        = fifo_rd_vld;
          wdata      = fifo_rd_data;
          fifo_rd_en = fifo_rd_vld & wready;
        end
        wvalid = w_v;
        if (frame_start) start_pend_d = 1'b1;
        if (w_v && wready) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (w_l) state_d = S_RESP;
        end
      end

      S_RESP: begin
        bready = 1'b1;
        if (frame_start) start_pend_d = 1'b1;
        if (bvalid) begin
          if (bresp != 2'b00) bresp_err_d = 1'b1;
          if (start_pend_q || (frame_start && !frame_last)) begin
            frame_abort  = 1'b1;
            start_pend_d = 1'b0;
            word_cnt_d   = '0;
            addr_d       = buf_base(buf_idx_q);
            state_d      = S_ADDR;
          end else if (frame_last) begin
            frame_done     = 1'b1;
            wr_frame_idx_d = buf_idx_q;
            buf_idx_d      = buf_next;
            start_pend_d   = 1'b0;
            word_cnt_d     = '0;
            if (frame_start) begin
              addr_d  = buf_base(buf_next);
              state_d = S_ADDR;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            word_cnt_d = word_cnt_q + WC_W'(blen_q);
            addr_d     = addr_q + ADDR_WIDTH'({blen_q, 4'b0000});
            state_d    = S_ADDR;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddr_frame_wr_sched.sv
// tb/tb_ddr_frame_wr_sched.sv - directed bench for ddr_frame_wr_sched with a 40-word frame
// A single driver/monitor process models the FIFO and the AXI slave; test tasks only request events.

module tb_ddr_frame_wr_sched;
  localparam int AW = 28;

  logic           clk = 1'b0;
  logic           rst;
  logic           frame_start;
  logic           fifo_rd_en;
  logic           fifo_rd_vld;
  logic [127:0]   fifo_rd_data;
  logic [AW-1:0]  awaddr;
  logic [7:0]     awlen;
  logic           awvalid;
  logic           awready;
  logic [127:0]   wdata;
  logic           wlast;
  logic           wvalid;
  logic           wready;
  logic           bvalid;
  logic [1:0]     bresp;
  logic           bready;
  logic [1:0]     wr_frame_idx;
  logic           frame_done;
  logic           frame_abort;
  logic           bresp_err;

  int errors = 0;
  int checks = 0;

  int vld_mode = 0;
  bit wready_rand = 1'b0;
  int start_req_cnt = 0;
  int err_req_cnt = 0;
  int arm_b = -1;

  logic [31:0]   head = 32'd1;
  bit            phase = 1'b0;
  bit            b_pend = 1'b0;
  int            start_ack_cnt = 0;
  int            err_ack_cnt = 0;
  logic [AW-1:0] aw_addr_log[$];
  logic [7:0]    aw_len_log[$];
  logic [127:0]  w_data_log[$];
  bit            w_pop_log[$];
  bit            w_last_log[$];
  int            done_cnt = 0;
  int            abort_cnt = 0;
  int            b_cnt = 0;
  int            pop_viol = 0;

  ddr_frame_wr_sched #(
    .ADDR_WIDTH(AW), .BURST_LEN(16), .FRAME_WORDS(40),
    .FRAME_BASE(32'h0), .FRAME_STRIDE(32'h0020_0000), .FRAME_NUM(3)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .wr_frame_idx(wr_frame_idx), .frame_done(frame_done),
    .frame_abort(frame_abort), .bresp_err(bresp_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] exp_word(input logic [31:0] v);
    return {~v, v, ~v, v};
  endfunction

  function automatic bit exp_last(input int i);
    return (i % 40 == 15) || (i % 40 == 31) || (i % 40 == 39);
  endfunction

  // Inputs change on the falling edge; 2 ns later the bench records what the next rising edge will accept.
  initial begin
    frame_start = 1'b0; fifo_rd_vld = 1'b0; fifo_rd_data = '0;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00;
    forever begin
      @(negedge clk);
      frame_start = 1'b0;
      if (start_req_cnt != start_ack_cnt) begin
        frame_start = 1'b1;
        start_ack_cnt++;
      end
      phase = ~phase;
      fifo_rd_vld  = (vld_mode == 0) ? 1'b1 : ((vld_mode == 1) ? phase : 1'b0);
      fifo_rd_data = exp_word(head);
      wready = wready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (rst) b_pend = 1'b0;
      bvalid = b_pend;
      bresp  = 2'b00;
      if (b_pend) begin
        if (err_req_cnt != err_ack_cnt) bresp = 2'b10;
        if (arm_b == b_cnt) frame_start = 1'b1;
      end
      #2;
      if (!rst) begin
        if (awvalid && awready) begin
          aw_addr_log.push_back(awaddr);
          aw_len_log.push_back(awlen);
        end
        if (fifo_rd_en && !(wvalid && wready)) pop_viol++;
        if (bvalid && bready) begin
          b_cnt++;
          b_pend = 1'b0;
          if (bresp != 2'b00) err_ack_cnt++;
        end
        if (wvalid && wready) begin
          w_data_log.push_back(wdata);
          w_pop_log.push_back(fifo_rd_en);
          w_last_log.push_back(wlast);
          if (wlast) b_pend = 1'b1;
        end
        if (fifo_rd_en && fifo_rd_vld) head++;
        if (frame_done) done_cnt++;
        if (frame_abort) abort_cnt++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "time limit");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    tick(3);
    checks++;
    if ({awvalid, wvalid, wlast, fifo_rd_en, bready, frame_done, frame_abort, bresp_err} !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes: got %b expected 00000000",
               {awvalid, wvalid, wlast, fifo_rd_en, bready, frame_done, frame_abort, bresp_err});
    end
    checks++;
    if (wr_frame_idx !== 2'd2) begin
      errors++; $display("FAIL reset_wr_frame_idx: got %0d expected 2", wr_frame_idx);
    end
    checks++;
    if (awaddr !== '0 || awlen !== 8'd0 || wdata !== '0) begin
      errors++; $display("FAIL reset_buses: got awaddr=%0h awlen=%0d wdata=%0h expected 0", awaddr, awlen, wdata);
    end
    rst = 1'b0;
    tick(10);
    checks++;
    if (aw_addr_log.size() !== 0) begin
      errors++; $display("FAIL reset_no_aw: got %0d bursts expected 0", aw_addr_log.size());
    end
  endtask

  task automatic test_single_frame();
    int sa, sw, d0, a0, bad_d, bad_l;
    logic [31:0] h0;
    bit ok;
    logic [AW-1:0] ea[3];
    logic [7:0] el[3];
    ea = '{28'h000, 28'h100, 28'h200};
    el = '{8'd15, 8'd15, 8'd7};
    sa = aw_addr_log.size(); sw = w_data_log.size(); d0 = done_cnt; a0 = abort_cnt; h0 = head;
    start_req_cnt++;
    wait_done(d0 + 1, 300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got timeout expected frame_done"); end
    tick(2);
    checks++;
    if (aw_addr_log.size() - sa !== 3 || w_data_log.size() - sw !== 40) begin
      errors++; $display("FAIL single_counts: got aw=%0d w=%0d expected aw=3 w=40",
                         aw_addr_log.size() - sa, w_data_log.size() - sw);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (aw_addr_log[sa+k] !== ea[k] || aw_len_log[sa+k] !== el[k]) begin
        errors++; $display("FAIL single_aw%0d: got addr=%0h len=%0d expected addr=%0h len=%0d",
                           k, aw_addr_log[sa+k], aw_len_log[sa+k], ea[k], el[k]);
      end
    end
    bad_d = 0; bad_l = 0;
    for (int i = 0; i < 40; i++) begin
      if (w_data_log[sw+i] !== exp_word(h0 + 32'(i)) || w_pop_log[sw+i] !== 1'b1) bad_d++;
      if (w_last_log[sw+i] !== exp_last(i)) bad_l++;
    end
    checks++;
    if (bad_d !== 0) begin errors++; $display("FAIL single_data: got %0d bad beats expected 0", bad_d); end
    checks++;
    if (bad_l !== 0) begin errors++; $display("FAIL single_wlast: got %0d bad beats expected 0", bad_l); end
    checks++;
    if (wr_frame_idx !== 2'd0 || done_cnt - d0 !== 1 || abort_cnt !== a0) begin
      errors++; $display("FAIL single_status: got idx=%0d done=%0d abort=%0d expected idx=0 done=1 abort=0",
                         wr_frame_idx, done_cnt - d0, abort_cnt - a0);
    end
  endtask

  task automatic test_back_to_back();
    int sa, sw, d0, a0, bad;
    logic [31:0] h0;
    bit ok;
    sa = aw_addr_log.size(); sw = w_data_log.size(); d0 = done_cnt; a0 = abort_cnt; h0 = head;
    start_req_cnt++;
    arm_b = b_cnt + 2;
    wait_done(d0 + 1, 300, ok);
    checks++;
    if (!ok || wr_frame_idx !== 2'd1) begin
      errors++; $display("FAIL b2b_frame1: got ok=%0d idx=%0d expected ok=1 idx=1", ok, wr_frame_idx);
    end
    wait_done(d0 + 2, 300, ok);
    checks++;
    if (!ok || wr_frame_idx !== 2'd2) begin
      errors++; $display("FAIL b2b_frame2: got ok=%0d idx=%0d expected ok=1 idx=2", ok, wr_frame_idx);
    end
    arm_b = -1;
    tick(3);
    start_req_cnt++;
    wait_done(d0 + 3, 300, ok);
    checks++;
    if (!ok || wr_frame_idx !== 2'd0) begin
      errors++; $display("FAIL b2b_frame3: got ok=%0d idx=%0d expected ok=1 idx=0", ok, wr_frame_idx);
    end
    tick(2);
    checks++;
    if (aw_addr_log.size() - sa !== 9 || abort_cnt !== a0) begin
      errors++; $display("FAIL b2b_counts: got aw=%0d abort=%0d expected aw=9 abort=0",
                         aw_addr_log.size() - sa, abort_cnt - a0);
    end
    checks++;
    if (aw_addr_log[sa] !== 28'h020_0000 || aw_addr_log[sa+3] !== 28'h040_0000 ||
        aw_addr_log[sa+4] !== 28'h040_0100 || aw_addr_log[sa+6] !== 28'h000_0000) begin
      errors++; $display("FAIL b2b_bases: got %0h %0h %0h %0h expected 200000 400000 400100 0",
                         aw_addr_log[sa], aw_addr_log[sa+3], aw_addr_log[sa+4], aw_addr_log[sa+6]);
    end
    bad = 0;
    for (int i = 0; i < 120; i++)
      if (w_data_log[sw+i] !== exp_word(h0 + 32'(i)) || w_last_log[sw+i] !== exp_last(i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL b2b_data: got %0d bad beats expected 0", bad); end
  endtask

  task automatic test_fifo_gaps();
    int sa, sw, d0, v0, bad_d, bad_l;
    logic [31:0] h0;
    bit ok;
    vld_mode = 1; wready_rand = 1'b1;
    sa = aw_addr_log.size(); sw = w_data_log.size(); d0 = done_cnt; v0 = pop_viol; h0 = head;
    start_req_cnt++;
    wait_done(d0 + 1, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL gaps_done: got timeout expected frame_done"); end
    vld_mode = 0; wready_rand = 1'b0;
    tick(2);
    bad_d = 0; bad_l = 0;
    for (int i = 0; i < 40; i++) begin
      if (w_data_log[sw+i] !== exp_word(h0 + 32'(i))) bad_d++;
      if (w_last_log[sw+i] !== exp_last(i)) bad_l++;
    end
    checks++;
    if (w_data_log.size() - sw !== 40 || bad_d !== 0) begin
      errors++; $display("FAIL gaps_order: got beats=%0d bad=%0d expected beats=40 bad=0",
                         w_data_log.size() - sw, bad_d);
    end
    checks++;
    if (bad_l !== 0) begin errors++; $display("FAIL gaps_wlast: got %0d bad beats expected 0", bad_l); end
    checks++;
    if (pop_viol !== v0) begin
      errors++; $display("FAIL gaps_pop: got %0d pops without W handshake expected 0", pop_viol - v0);
    end
    checks++;
    if (aw_addr_log[sa] !== 28'h020_0000 || wr_frame_idx !== 2'd1) begin
      errors++; $display("FAIL gaps_buf: got addr=%0h idx=%0d expected addr=200000 idx=1",
                         aw_addr_log[sa], wr_frame_idx);
    end
  endtask

  task automatic test_abort_mid_burst();
    int sa, sw, d0, a0, bad;
    logic [31:0] h0;
    bit ok, hit;
    sa = aw_addr_log.size(); sw = w_data_log.size(); d0 = done_cnt; a0 = abort_cnt; h0 = head;
    start_req_cnt++;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      tick(1);
      if (w_data_log.size() - sw == 21) begin
        start_req_cnt++;
        hit = 1'b1;
      end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL abort_reach_beat: got timeout expected beat 5 of burst 2"); end
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (abort_cnt > a0) ok = 1'b1;
    end
    checks++;
    if (!ok || wr_frame_idx !== 2'd1 || done_cnt !== d0) begin
      errors++; $display("FAIL abort_pulse: got ok=%0d idx=%0d done=%0d expected ok=1 idx=1 done=0",
                         ok, wr_frame_idx, done_cnt - d0);
    end
    wait_done(d0 + 1, 300, ok);
    checks++;
    if (!ok || wr_frame_idx !== 2'd2 || abort_cnt - a0 !== 1) begin
      errors++; $display("FAIL abort_rewrite_done: got ok=%0d idx=%0d aborts=%0d expected ok=1 idx=2 aborts=1",
                         ok, wr_frame_idx, abort_cnt - a0);
    end
    tick(2);
    checks++;
    if (w_data_log[sw+21] !== exp_word(h0 + 32'd21) || w_pop_log[sw+21] !== 1'b1) begin
      errors++; $display("FAIL abort_beat5: got %0h pop=%0d expected %0h pop=1",
                         w_data_log[sw+21], w_pop_log[sw+21], exp_word(h0 + 32'd21));
    end
    bad = 0;
    for (int i = 22; i < 32; i++)
      if (w_data_log[sw+i] !== '0 || w_pop_log[sw+i] !== 1'b0) bad++;
    checks++;
    if (bad !== 0 || w_last_log[sw+31] !== 1'b1) begin
      errors++; $display("FAIL abort_padding: got %0d bad pad beats wlast=%0d expected 0 and 1",
                         bad, w_last_log[sw+31]);
    end
    checks++;
    if (aw_addr_log.size() - sa !== 5 || aw_addr_log[sa] !== 28'h040_0000 ||
        aw_addr_log[sa+1] !== 28'h040_0100 || aw_addr_log[sa+2] !== 28'h040_0000) begin
      errors++; $display("FAIL abort_aw: got n=%0d %0h %0h %0h expected n=5 400000 400100 400000",
                         aw_addr_log.size() - sa, aw_addr_log[sa], aw_addr_log[sa+1], aw_addr_log[sa+2]);
    end
    bad = 0;
    for (int j = 0; j < 40; j++)
      if (w_data_log[sw+32+j] !== exp_word(h0 + 32'd22 + 32'(j)) || w_last_log[sw+32+j] !== exp_last(j)) bad++;
    checks++;
    if (w_data_log.size() - sw !== 72 || bad !== 0) begin
      errors++; $display("FAIL abort_restart_data: got beats=%0d bad=%0d expected beats=72 bad=0",
                         w_data_log.size() - sw, bad);
    end
  endtask

  task automatic test_bresp_err();
    int sa, d0;
    bit ok;
    checks++;
    if (bresp_err !== 1'b0) begin errors++; $display("FAIL bresp_err_clear: got %0d expected 0", bresp_err); end
    sa = aw_addr_log.size(); d0 = done_cnt;
    err_req_cnt++;
    start_req_cnt++;
    wait_done(d0 + 1, 300, ok);
    checks++;
    if (!ok || bresp_err !== 1'b1) begin
      errors++; $display("FAIL bresp_err_set: got ok=%0d err=%0d expected ok=1 err=1", ok, bresp_err);
    end
    tick(5);
    checks++;
    if (bresp_err !== 1'b1 || wr_frame_idx !== 2'd0 || aw_addr_log[sa] !== 28'h0) begin
      errors++; $display("FAIL bresp_err_sticky: got err=%0d idx=%0d addr=%0h expected err=1 idx=0 addr=0",
                         bresp_err, wr_frame_idx, aw_addr_log[sa]);
    end
  endtask

  task automatic test_reset_mid_data();
    int sa, sw, d0;
    bit ok;
    sw = w_data_log.size();
    start_req_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick(1);
      if (w_data_log.size() - sw >= 5) ok = 1'b1;
    end
    checks++;
    if (!ok || wvalid !== 1'b1) begin
      errors++; $display("FAIL rst_mid_reach: got ok=%0d wvalid=%0d expected 1 1", ok, wvalid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({awvalid, wvalid, wlast, fifo_rd_en, bready, frame_done, frame_abort, bresp_err} !== 8'h00 || wdata !== '0) begin
      errors++; $display("FAIL rst_mid_async: got %b wdata=%0h expected 00000000 wdata=0",
                         {awvalid, wvalid, wlast, fifo_rd_en, bready, frame_done, frame_abort, bresp_err}, wdata);
    end
    checks++;
    if (wr_frame_idx !== 2'd2) begin
      errors++; $display("FAIL rst_mid_idx: got %0d expected 2", wr_frame_idx);
    end
    tick(2);
    rst = 1'b0;
    sa = aw_addr_log.size();
    tick(30);
    checks++;
    if (aw_addr_log.size() !== sa) begin
      errors++; $display("FAIL rst_mid_no_aw: got %0d bursts expected 0", aw_addr_log.size() - sa);
    end
    d0 = done_cnt;
    start_req_cnt++;
    wait_done(d0 + 1, 300, ok);
    checks++;
    if (!ok || aw_addr_log[sa] !== 28'h0 || wr_frame_idx !== 2'd0) begin
      errors++; $display("FAIL rst_mid_restart: got ok=%0d addr=%0h idx=%0d expected ok=1 addr=0 idx=0",
                         ok, aw_addr_log[sa], wr_frame_idx);
    end
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_fifo_gaps();
    test_abort_mid_burst();
    test_bresp_err();
    test_reset_mid_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
